ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, between ID and MEM.
- Registers the ID→EX bus, selects ALU operands, runs the 12-op ALU and issues the data-SRAM request.
- Produces the EX→MEM bus and the EX forwarding/load-use signals consumed by ID.
- Optional iterative divider with HI/LO registers; stalls the pipeline while it is busy.

---
 rtl/ex_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID->EX stage register, operand select, 12-op ALU, data-SRAM request, EX forwarding.
// Optional iterative divider with HI/LO registers, enabled by defining DIV_EN.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int DIV_CYCLES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_opl,
    output logic                    stallreq_for_ex
);
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

    logic [ID_TO_EX_WD-1:0] bus_q;
    logic stage_bubble, stage_load, stage_change;

    assign stage_bubble = stall[2] & ~stall[3];
    assign stage_load   = ~stall[2];
    assign stage_change = stage_bubble | stage_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              bus_q <= '0;
        else if (stage_bubble) bus_q <= '0;
        else if (stage_load)   bus_q <= id_to_ex_bus;
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    assign pc         = bus_q[158:127];
    assign inst       = bus_q[126:95];
    assign alu_op     = bus_q[94:83];
    assign sel_src1   = bus_q[82:80];
    assign sel_src2   = bus_q[79:76];
    assign ram_en     = bus_q[75];
    assign ram_wen    = bus_q[74:71];
    assign rf_we      = bus_q[70];
    assign rf_waddr   = bus_q[69:65];
    assign sel_rf_res = bus_q[64];
    assign rdata1     = bus_q[63:32];
    assign rdata2     = bus_q[31:0];

    // Selects are one-hot; an empty select yields zero.
    logic [31:0] src1, src2, alu_res, ex_result;
    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

    always_comb begin
        alu_res = '0;
        if (alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_res = alu_res | {31'b0, src1 < src2};
        if (alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
        if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_res = alu_res | $unsigned($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

`ifdef DIV_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] quo, dvs, rem, hi, lo;
    logic        neg_q, neg_r, dvs_zero, div_done;
    logic        is_div, is_divs, is_mfhi, is_mflo, div_start;
    logic [32:0] trial;

    assign is_divs   = (inst[31:26] == 6'd0) && (inst[5:0] == 6'h1A);
    assign is_div    = is_divs || ((inst[31:26] == 6'd0) && (inst[5:0] == 6'h1B));
    assign is_mfhi   = (inst[31:26] == 6'd0) && (inst[5:0] == 6'h10);
    assign is_mflo   = (inst[31:26] == 6'd0) && (inst[5:0] == 6'h12);
    assign div_start = is_div && !div_done;

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    assign trial = {rem, quo[31]} - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvs_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (div_start) begin
                    quo      <= (is_divs && rdata1[31]) ? -rdata1 : rdata1;
                    dvs      <= (is_divs && rdata2[31]) ? -rdata2 : rdata2;
                    neg_q    <= is_divs && (rdata1[31] ^ rdata2[31]);
                    neg_r    <= is_divs && rdata1[31];
                    dvs_zero <= (rdata2 == 32'd0);
                    rem      <= '0;
                    cnt      <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    quo <= {quo[30:0], ~trial[32]};
                    rem <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == DIV_LAST) state <= S_DONE;
                end
                S_DONE: begin
                    // With a zero divisor the remainder is |dividend|, so the sign fix restores the dividend.
                    hi    <= neg_r ? -rem : rem;
                    lo    <= dvs_zero ? 32'hFFFF_FFFF : (neg_q ? -quo : quo);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (stage_change)         div_done <= 1'b0;
            else if (state == S_DONE) div_done <= 1'b1;
        end
    end

    assign stallreq_for_ex = (state == S_RUN) || ((state == S_IDLE) && div_start);
    assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
`else
    assign stallreq_for_ex = 1'b0;
    assign ex_result       = alu_res;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[31:16], DIV_LAST};
`endif

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;

    assign ex_wreg  = rf_we;
    assign ex_waddr = rf_waddr;
    assign ex_wdata = ex_result;
    assign ex_opl   = sel_rf_res;

    assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; divider checks are compiled in when DIV_EN is defined.
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [5:0]   man_stall = '0;
    logic [5:0]   stall;
    logic [158:0] id_bus = '0;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en, ex_wreg, ex_opl, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, ex_wdata;
    logic [4:0]   ex_waddr;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_opl(ex_opl), .stallreq_for_ex(stallreq_for_ex)
    );

    always #5 clk = ~clk;

    // Stall controller: an EX request freezes PC..EX and lets MEM drain.
    assign stall = stallreq_for_ex ? 6'b001111 : man_stall;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [158:0] b);
        id_bus = b;
        step();
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ram_en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sel,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ram_en, wen, we, wa, sel, r1, r2};
    endfunction

    typedef struct {
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic [31:0] inst, r1, r2, exp;
    } vec_t;

    vec_t vt[15];

    localparam logic [31:0] PC0 = 32'hBFC0_0000;
    localparam logic [31:0] MFLO = 32'h0000_2812;
    localparam logic [31:0] MFHI = 32'h0000_2810;

    initial begin
        int cyc;
        vt[0]  = '{12'h400, 3'b001, 4'b0001, 32'h0,         32'd5,         32'd7,         32'hFFFF_FFFE};
        vt[1]  = '{12'h200, 3'b001, 4'b0001, 32'h0,         32'hFFFF_FFFF, 32'd1,         32'd1};
        vt[2]  = '{12'h100, 3'b001, 4'b0001, 32'h0,         32'hFFFF_FFFF, 32'd1,         32'd0};
        vt[3]  = '{12'h080, 3'b001, 4'b0001, 32'h0,         32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234};
        vt[4]  = '{12'h040, 3'b001, 4'b0001, 32'h0,         32'hF0F0_0000, 32'h0000_000F, 32'h0F0F_FFF0};
        vt[5]  = '{12'h020, 3'b001, 4'b0001, 32'h0,         32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vt[6]  = '{12'h010, 3'b001, 4'b0001, 32'h0,         32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vt[7]  = '{12'h008, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h8000_0001, 32'h0000_0010};
        vt[8]  = '{12'h004, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h8000_0000, 32'h0800_0000};
        vt[9]  = '{12'h002, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h8000_0000, 32'hF800_0000};
        vt[10] = '{12'h001, 3'b000, 4'b1000, 32'h3C05_1234, 32'h0,         32'h0,         32'h1234_0000};
        vt[11] = '{12'h800, 3'b010, 4'b0100, 32'h0,         32'h0,         32'h0,         32'hBFC0_0008};
        vt[12] = '{12'h004, 3'b001, 4'b0001, 32'h0,         32'h0000_0024, 32'hFFFF_FFF0, 32'h0FFF_FFFF};
        vt[13] = '{12'h000, 3'b001, 4'b0001, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, 32'h0};
        vt[14] = '{12'h800, 3'b001, 4'b1000, 32'h3405_FFFC, 32'h0,         32'h0,         32'h0000_FFFC};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus", ex_to_mem_bus, 76'd0);
        chk("rst_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
        chk("rst_fwd", 76'({ex_wreg, ex_waddr, ex_wdata, ex_opl, stallreq_for_ex}), 76'd0);
        @(negedge clk) rst = 1'b1;

        // addiu $5, $x, 1 with rs = -1
        issue(mk(PC0, 32'h2405_0001, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0,
                 32'hFFFF_FFFF, 32'h0));
        chk("addiu_fwd", 76'({ex_wreg, ex_waddr, ex_wdata}), 76'({1'b1, 5'd5, 32'h0}));
        chk("addiu_bus", ex_to_mem_bus, {PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0});

        issue(mk(PC0 + 4, 32'h8C05_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd5, 1'b1,
                 32'h0000_1000, 32'h0));
        chk("lw_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr}), 76'({1'b1, 4'h0, 32'h0FFC}));
        chk("lw_opl", 76'({ex_opl, ex_to_mem_bus[43], ex_to_mem_bus[38]}), 76'(3'b111));

        issue(mk(PC0 + 8, 32'hAC05_0000, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                 32'h0000_0020, 32'hDEAD_BEEF));
        chk("sw_sram", 76'({data_sram_wen, data_sram_addr, data_sram_wdata}),
            76'({4'hF, 32'h20, 32'hDEAD_BEEF}));
        chk("sw_wreg", 76'(ex_wreg), 76'd0);

        // Hold: stall[2]=stall[3]=Stop keeps the sw even though a new bus is presented.
        man_stall = 6'b001111;
        issue(mk(PC0, 32'h2405_0001, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
                 32'h1, 32'h2));
        chk("hold_sram", 76'({data_sram_en, data_sram_addr, data_sram_wdata}),
            76'({1'b1, 32'h20, 32'hDEAD_BEEF}));
        man_stall = 6'b000111;
        step();
        chk("bubble_bus", ex_to_mem_bus, 76'd0);
        chk("bubble_out", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                               ex_wreg, ex_waddr, ex_opl}), 76'd0);
        man_stall = 6'b000000;

        for (int i = 0; i < 15; i++) begin
            issue(mk(PC0, vt[i].inst, vt[i].op, vt[i].s1, vt[i].s2, 1'b0, 4'h0, 1'b1, 5'(i), 1'b0,
                     vt[i].r1, vt[i].r2));
            chk($sformatf("alu_%0d", i), 76'({ex_waddr, ex_wdata}), 76'({5'(i), vt[i].exp}));
        end

`ifdef DIV_EN
        // div -7 / 2
        issue(mk(PC0, 32'h0085_001A, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFF_FFF9, 32'd2));
        id_bus = mk(PC0, MFLO, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0);
        cyc = 0;
        while (stallreq_for_ex && cyc < 100) begin cyc++; step(); end
        chk("div_stall_cycles", 76'(cyc), 76'd33);
        man_stall = 6'b001111;
        step();
        chk("div_once", 76'(stallreq_for_ex), 76'd0);
        man_stall = 6'b000000;
        step();
        chk("div_mflo", 76'(ex_wdata), 76'(32'hFFFF_FFFD));
        issue(mk(PC0, MFHI, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0));
        chk("div_mfhi", 76'(ex_wdata), 76'(32'hFFFF_FFFF));

        // divu 100 / 0 interrupted by reset in the middle of RUN
        issue(mk(PC0, 32'h0085_001B, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd100, 32'd0));
        repeat (10) step();
        chk("divu_running", 76'(stallreq_for_ex), 76'd1);
        rst = 1'b0;
        #1;
        chk("divu_rst_out", 76'({stallreq_for_ex, ex_wreg, ex_wdata}), 76'd0);
        chk("divu_rst_bus", ex_to_mem_bus, 76'd0);
        @(negedge clk) rst = 1'b1;
        issue(mk(PC0, MFHI, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0));
        chk("hi_after_rst", 76'(ex_wdata), 76'd0);

        issue(mk(PC0, 32'h0085_001B, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd100, 32'd0));
        id_bus = mk(PC0, MFLO, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0);
        cyc = 0;
        while (stallreq_for_ex && cyc < 100) begin cyc++; step(); end
        chk("divu0_stall_cycles", 76'(cyc), 76'd33);
        step();
        chk("divu0_mflo", 76'(ex_wdata), 76'(32'hFFFF_FFFF));
        issue(mk(PC0, MFHI, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0));
        chk("divu0_mfhi", 76'(ex_wdata), 76'd100);
`else
        issue(mk(PC0, 32'h0085_001A, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFF_FFF9, 32'd2));
        chk("nodiv_stallreq", 76'(stallreq_for_ex), 76'd0);
        step();
        chk("nodiv_stallreq2", 76'(stallreq_for_ex), 76'd0);
        issue(mk(PC0, MFLO, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0));
        chk("nodiv_mflo", 76'({ex_wreg, ex_wdata}), 76'({1'b1, 32'h0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
